fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
//  Parametrised fetch-stage program counter for the MIPS pipeline.
//  Generalises the plain PC register: adds a valid/ready handshake to instruction memory,
//  stall, branch/jump redirect, exception vector, halt, post-redirect bubble and a fetch counter.
//  Sits between the next-PC logic of EX/ID and the instruction memory port of IF.
// PARAMETERS
//  PC_W         32            PC width in bits
//  RESET_PC     32'h0000_0000 PC value loaded by reset
//  EXC_VEC      32'h0000_0080 PC loaded on exception request
//  INSTR_BYTES  4             sequential increment; power of two, >= 1
//  BUBBLE_CYC   1             fetch_valid-low cycles after a redirect or exception; 1..15
//  CNT_W        32            fetch counter width
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      synchronous reset, active-high
//  fetch_ready    in   1      imem accepts the presented PC this cycle
//  stall          in   1      hazard stall from ID; holds PC and drops fetch_valid
//  redirect_valid in   1      branch/jump taken; one-cycle pulse
//  redirect_pc    in   PC_W   redirect target
//  exc_req        in   1      exception request; one-cycle pulse
//  halt_req       in   1      stop fetching; level, sampled in RUN only
//  pc             out  PC_W   current fetch PC, registered
//  pc_plus        out  PC_W   pc + INSTR_BYTES, combinational; used as link value
//  fetch_valid    out  1      pc is a valid fetch request
//  flush          out  1      registered one-cycle pulse: kill younger in-flight instructions
//  fetch_count    out  CNT_W  number of accepted fetches
//  misalign       out  1      only with FETCH_PC_ALIGN_CHECK_EN; registered pulse
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=IDLE, fetch_valid=0, flush=0, fetch_count=0, misalign=0, bubble counter=0.
//  - fire = fetch_valid & fetch_ready.
//  - fetch_valid = (state==RUN) & ~stall.
//  - seq_pc = pc + INSTR_BYTES, modulo 2^PC_W. All-ones minus INSTR_BYTES+1 wraps to 0 with no flag.
//  - Update priority, every state: exc_req > redirect_valid > halt_req > fire > hold.
//  - exc_req or redirect_valid, in any state including IDLE:
//    - next cycle: pc = EXC_VEC or redirect_pc, flush=1, state=BUBBLE.
//    - bubble counter is reloaded to BUBBLE_CYC.
//    - stall does not block a redirect.
//  - IDLE: lasts exactly one cycle after reset release, then goes to RUN.
//  - RUN, in priority order:
//    - halt_req: state=HALT, pc held.
//    - fire: pc = seq_pc, fetch_count += 1 (wraps).
//    - otherwise: pc held.
//    - While fetch_valid & ~fetch_ready, pc must stay stable until fire.
//  - BUBBLE: fetch_valid=0.
//    - Counter decrements each cycle; state returns to RUN on the cycle after it reaches 0.
//    - A new redirect or exception restarts the bubble.
//  - HALT: fetch_valid=0.
//    - halt_req is ignored.
//    - Exit is only via exc_req or redirect_valid, into BUBBLE.
//  - flush is high only on the cycle after an accepted redirect or exception.
//  - Redirect and exception on the same cycle: the exception wins; redirect_pc is discarded.
//  - A fire on the same cycle as a redirect is not counted.
// CONFIGURATION
//  FETCH_PC_ALIGN_CHECK_EN defined:
//    - redirect_pc with low log2(INSTR_BYTES) bits nonzero is not loaded.
//    - Instead: pc=EXC_VEC, misalign=1, flush=1, state=BUBBLE.
//  FETCH_PC_ALIGN_CHECK_EN undefined:
//    - The misalign port is absent.
//    - Low log2(INSTR_BYTES) bits of redirect_pc are forced to 0 before loading.
// STRUCTURE
//  fetch_pc_pkg:
//    - state enum {IDLE, RUN, BUBBLE, HALT}, 2 bits.
//    - Default RESET_PC and EXC_VEC constants.
//    - ALIGN_LSB = $clog2(INSTR_BYTES).
//  Sub-module fetch_pc_next: combinational next-PC and next-state select (priority mux plus alignment mask).
//  Registers (pc, state, bubble counter, fetch_count, flush) stay in fetch_pc_unit.
// TESTING
//  1 Reset: rst high 2 cycles, then low.
//    -> pc=0, fetch_valid=0 for 1 cycle, then 1; fetch_count=0.
//  2 Sequential fetch: fetch_ready=1 for 4 cycles.
//    -> pc 0,4,8,C,10; fetch_count=4.
//    fetch_ready=0 for 3 cycles -> pc held at 0x10.
//  3 Redirect under stall: stall=1, redirect_pc=0x200.
//    -> next cycle pc=0x200, flush=1, fetch_valid=0 for BUBBLE_CYC=1 cycle.
//    Then fetch_valid = ~stall.
//  4 Simultaneous events: exc_req=1 and redirect_valid=1 (pc 0x300).
//    -> pc=0x80, flush=1, fetch_count unchanged.
//  5 Halt: halt_req=1 in RUN -> HALT, fetch_valid=0, pc held for 10 cycles.
//    redirect 0x40 -> pc=0x40, RUN after bubble.
//  6 Wrap and alignment: pc=0xFFFF_FFFC, fire -> pc=0, count+1.
//    With macro: redirect_pc=0x102 -> pc=0x80, misalign=1.
//    Without macro: redirect_pc=0x102 -> pc=0x100.

Source files
------------

// File: rtl/fetch_pc_pkg.sv
// fetch_pc_pkg: state encoding, default vectors and alignment helper shared by the fetch PC unit.
package fetch_pc_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BUBBLE, ST_HALT} state_t;
    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC     = 32'h0000_0080;
    localparam int          DEF_INSTR_BYTES = 4;
    localparam int          ALIGN_LSB       = $clog2(DEF_INSTR_BYTES);
    function automatic int align_lsb(input int bytes);
        return $clog2(bytes);
    endfunction
endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: combinational next-PC / next-state priority select for the fetch PC unit.
// Alignment handling depends on FETCH_PC_ALIGN_CHECK_EN (trap misaligned redirects) vs. masking.
module fetch_pc_next import fetch_pc_pkg::*; #(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] EXC_VEC     = PC_W'(DEF_EXC_VEC),
    parameter int              INSTR_BYTES = 4,
    parameter int              BUBBLE_CYC  = 1
) (
    input  state_t          i_state,
    input  logic [PC_W-1:0] i_pc,
    input  logic [3:0]      i_bub,
    input  logic            i_stall,
    input  logic            i_fetch_ready,
    input  logic            i_redirect_valid,
    input  logic [PC_W-1:0] i_redirect_pc,
    input  logic            i_exc_req,
    input  logic            i_halt_req,
    output state_t          o_state,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_plus,
    output logic [3:0]      o_bub,
    output logic            o_fetch_valid,
    output logic            o_count_en,
    output logic            o_flush
`ifdef FETCH_PC_ALIGN_CHECK_EN
    ,
    output logic            o_misalign
`endif
);
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'((64'd1 << align_lsb(INSTR_BYTES)) - 64'd1);
    logic            w_fire;
    logic            w_redir;
    logic [PC_W-1:0] w_target;
    assign o_pc_plus     = i_pc + PC_W'(INSTR_BYTES);
    assign o_fetch_valid = (i_state == ST_RUN) & ~i_stall;
    assign w_fire        = o_fetch_valid & i_fetch_ready;
    assign w_redir       = i_exc_req | i_redirect_valid;
    assign o_flush       = w_redir;
`ifdef FETCH_PC_ALIGN_CHECK_EN
    logic w_bad;
    assign w_bad      = ~i_exc_req & (|(i_redirect_pc & LOW_MASK));
    assign o_misalign = i_redirect_valid & w_bad;
    assign w_target   = (i_exc_req | w_bad) ? EXC_VEC : i_redirect_pc;
`else
    assign w_target   = i_exc_req ? EXC_VEC : (i_redirect_pc & ~LOW_MASK);
`endif
    always_comb begin
        o_pc       = i_pc;
        o_state    = i_state;
        o_bub      = i_bub;
        o_count_en = 1'b0;
        if (w_redir) begin
            o_pc    = w_target;
            o_state = ST_BUBBLE;
            o_bub   = 4'(BUBBLE_CYC);
        end else if (i_state == ST_IDLE) begin
            o_state = ST_RUN;
        end else if (i_state == ST_BUBBLE) begin
            o_bub   = i_bub - 4'd1;
            o_state = (i_bub <= 4'd1) ? ST_RUN : ST_BUBBLE;
        end else if (i_state == ST_RUN && i_halt_req) begin
            o_state = ST_HALT;
        end else if (w_fire) begin
            o_pc       = o_pc_plus;
            o_count_en = 1'b1;
        end
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage program counter with imem handshake, stall, redirect, exception, halt and bubble.
// Optional FETCH_PC_ALIGN_CHECK_EN adds the misalign output and traps misaligned redirect targets.
module fetch_pc_unit import fetch_pc_pkg::*; #(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = PC_W'(DEF_RESET_PC),
    parameter logic [PC_W-1:0] EXC_VEC     = PC_W'(DEF_EXC_VEC),
    parameter int              INSTR_BYTES = 4,
    parameter int              BUBBLE_CYC  = 1,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_ready,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             exc_req,
    input  logic             halt_req,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus,
    output logic             fetch_valid,
    output logic             flush,
    output logic [CNT_W-1:0] fetch_count
`ifdef FETCH_PC_ALIGN_CHECK_EN
    ,
    output logic             misalign
`endif
);
    state_t           r_state;
    state_t           w_state;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc;
    logic [3:0]       r_bub;
    logic [3:0]       w_bub;
    logic [CNT_W-1:0] r_count;
    logic             r_flush;
    logic             w_flush;
    logic             w_count_en;
`ifdef FETCH_PC_ALIGN_CHECK_EN
    logic             r_misalign;
    logic             w_misalign;
    assign misalign = r_misalign;
`endif
    fetch_pc_next #(
        .PC_W(PC_W), .EXC_VEC(EXC_VEC), .INSTR_BYTES(INSTR_BYTES), .BUBBLE_CYC(BUBBLE_CYC)
    ) u_next (
        .i_state(r_state), .i_pc(r_pc), .i_bub(r_bub), .i_stall(stall),
        .i_fetch_ready(fetch_ready), .i_redirect_valid(redirect_valid),
        .i_redirect_pc(redirect_pc), .i_exc_req(exc_req), .i_halt_req(halt_req),
        .o_state(w_state), .o_pc(w_pc), .o_pc_plus(pc_plus), .o_bub(w_bub),
        .o_fetch_valid(fetch_valid), .o_count_en(w_count_en), .o_flush(w_flush)
`ifdef FETCH_PC_ALIGN_CHECK_EN
        , .o_misalign(w_misalign)
`endif
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_state    <= ST_IDLE;
            r_bub      <= 4'd0;
            r_count    <= '0;
            r_flush    <= 1'b0;
`ifdef FETCH_PC_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_pc       <= w_pc;
            r_state    <= w_state;
            r_bub      <= w_bub;
            r_count    <= w_count_en ? r_count + CNT_W'(1) : r_count;
            r_flush    <= w_flush;
`ifdef FETCH_PC_ALIGN_CHECK_EN
            r_misalign <= w_misalign;
`endif
        end
    end
    assign pc          = r_pc;
    assign flush       = r_flush;
    assign fetch_count = r_count;
endmodule
